// File: rtl/alu_shift_pkg.sv
// Shared definitions for the ALU shift datapath (left and right shift paths).
package alu_shift_pkg;

    localparam int DATA_WIDTH = 32;

    // Shift-op encoding shared with the right-shift path
    localparam logic SHIFT_LOGICAL = 1'b0;
    localparam logic SHIFT_ROTATE  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } lshift_state_t;

endpackage

// File: rtl/lshift_step.sv
// One combinational left-shift stage: shifts by 2^stage when en is set,
// filling with zero (logical) or the wrapped MSBs (rotate).
module lshift_step #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   data,
    input  logic [SHAMT_W-1:0] stage,
    input  logic               en,
    input  logic               rotate,
    output logic [WIDTH-1:0]   q
);

    logic [SHAMT_W-1:0][WIDTH-1:0] cand;
    logic [WIDTH-1:0]              shifted;

    // Precompute every stage's shifted vector; the low 2^k bits pick fill vs wrap
    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int D = 1 << k;
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= D) begin : g_move
                assign cand[k][i] = data[i-D];
            end else begin : g_fill
                mux2x1_1b u_fill (
                    .sel (rotate),
                    .a   (1'b0),
                    .b   (data[WIDTH-D+i]),
                    .y   (cand[k][i])
                );
            end
        end
    end

    always_comb begin
        shifted = data;
        for (int k = 0; k < SHAMT_W; k++) begin
            if (stage == SHAMT_W'(k)) shifted = cand[k];
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_out
        mux2x1_1b u_out (
            .sel (en),
            .a   (data[i]),
            .b   (shifted[i]),
            .y   (q[i])
        );
    end

endmodule

// File: rtl/mux2x1_1b.sv
// Single-bit 2:1 mux cell used by the shift stages.
module mux2x1_1b (
    input  logic sel,
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/lshift_iter.sv
// Iterative left shifter/rotator: one log2 stage per clock between
// a valid/ready operand handshake and a valid/ready result handshake.
module lshift_iter
    import alu_shift_pkg::*;
#(
    parameter int WIDTH   = DATA_WIDTH,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic               in_rotate,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
);

    localparam logic [SHAMT_W-1:0] LAST_STAGE = SHAMT_W'(SHAMT_W - 1);

    lshift_state_t      state, state_next;
    logic [WIDTH-1:0]   data_q, res_q, step_q;
    logic [SHAMT_W-1:0] shamt_q, stage_q;
    logic               rot_q;
    logic               last_stage;

    assign last_stage = (stage_q == LAST_STAGE);
    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign out_data   = res_q;

    lshift_step #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_step (
        .data   (data_q),
        .stage  (stage_q),
        .en     (shamt_q[stage_q]),
        .rotate (rot_q == SHIFT_ROTATE),
        .q      (step_q)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)   state_next = SHIFT;
            SHIFT:   if (last_stage) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            data_q  <= '0;
            res_q   <= '0;
            shamt_q <= '0;
            stage_q <= '0;
            rot_q   <= SHIFT_LOGICAL;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (in_valid) begin
                    data_q  <= in_data;
                    shamt_q <= in_shamt;
                    rot_q   <= in_rotate;
                    stage_q <= '0;
                end
                SHIFT: begin
                    data_q  <= step_q;
                    stage_q <= stage_q + 1'b1;
                    // result register keeps out_data stable outside DONE
                    if (last_stage) res_q <= step_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/lshift_iter.md
Name: lshift_iter

Overview:
- Multi-cycle iterative left shifter/rotator: the left-direction counterpart of the right barrel-shift stages in the ALU shifter datapath.
- Accepts one 32-bit operand plus shift amount over a valid/ready handshake.
- Applies one log2 stage (1, 2, 4, 8, 16) per clock, driven by an internal stage counter.
- Returns the result over a second valid/ready handshake. Serves SLL and ROL when area matters more than single-cycle latency.

Parameters:
- WIDTH, 32, operand width; must be a power of two >= 2.
- SHAMT_W, $clog2(WIDTH), shift-amount width; also the number of stages.

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous reset, active-low
- in_valid  input  1  operand offered
- in_ready  output  1  block can accept operand
- in_data  input  WIDTH  operand
- in_shamt  input  SHAMT_W  left shift amount
- in_rotate  input  1  1 = rotate left (wrap MSBs into LSBs), 0 = logical left (fill 0)
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_data  output  WIDTH  shifted/rotated result

Behaviour:
- Reset: one clock (clk); asynchronous, active-low reset (n_rst). While n_rst=0: state=IDLE, data/shamt/rotate/stage registers=0, out_valid=0, out_data=0, in_ready=1 (in_ready = state==IDLE). Reset asserted mid-operation aborts immediately; the partial result is discarded with no output.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid && in_ready at edge T: latch in_data, in_shamt, in_rotate; stage<=0; go to SHIFT.
  - SHIFT: in_ready=0, out_valid=0. Each edge applies stage k = stage counter: if shamt[k], data <= data shifted left by 2^k. Fill is zero for logical; the top 2^k bits wrap to the bottom for rotate. If shamt[k]=0, data holds. stage<=stage+1. On the edge where k==SHAMT_W-1, go to DONE.
  - DONE: out_valid=1, out_data=data (registered, stable). in_ready=0. On out_valid && out_ready: go to IDLE, out_valid falls next cycle.
- Latency is fixed and independent of shamt. Operand accepted at edge T; stages apply at edges T+1..T+SHAMT_W; out_valid is high after edge T+SHAMT_W (5 cycles for WIDTH=32). shamt=0 still takes the full latency.
- Throughput: with out_ready held 1 and in_valid held 1, one result every SHAMT_W+2 cycles (7). There is no overlap of operand acceptance with DONE.
- Backpressure: while DONE && !out_ready, out_data and out_valid hold indefinitely. in_valid is ignored: not accepted, no state change.
- in_data, in_shamt and in_rotate are sampled only at acceptance. Changes afterwards have no effect.
- out_data outside DONE holds the last completed result (0 after reset); only DONE qualifies it.
- Stage counter width is SHAMT_W bits and never wraps during operation. The SHIFT exit is by compare, not by overflow.
- No illegal states are reachable; the default branch returns to IDLE.

Decomposition:
- Shared package (alu_shift_pkg):
  - state enum lshift_state_t {IDLE, SHIFT, DONE}
  - WIDTH default constant
  - shift-op encoding (SHIFT_LOGICAL=0, SHIFT_ROTATE=1), also consumed by the right-shift path
- One sub-module, lshift_step (combinational): inputs data[WIDTH], stage index, en, rotate; output data shifted left by 2^stage. Built from mux2x1_1b per bit, with a fill select of zero vs wrapped bit.
- The top level holds the FSM, counter and registers.

Test Plan:
- in_data=0x00000001, in_shamt=31, rotate=0 -> out_data=0x80000000; out_valid rises exactly 5 cycles after the accept edge.
- in_data=0x80000001, in_shamt=1: rotate=1 -> 0x00000003; rotate=0 -> 0x00000002.
- in_data=0xDEADBEEF, in_shamt=0 -> out_data=0xDEADBEEF, latency still 5. Then in_shamt=16, rotate=1 -> 0xBEEFDEAD.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while pulsing in_valid with new data -> out_valid and out_data stable, in_ready=0, second operand not accepted. Raise out_ready -> IDLE next cycle.
- Reset: drop n_rst during SHIFT (stage 2) -> out_valid=0, out_data=0, in_ready=1 asynchronously. After release, a new operand 0x0000000F, shamt=4 -> 0x000000F0.
- Back-to-back: in_valid=1 and out_ready=1 continuously, 4 random operands -> results match the reference model in order, one every 7 cycles, none dropped or duplicated.
